// File: rtl/regfile_exec_pkg.sv
// Shared opcode encoding, default widths and opcode-class helpers for regfile_exec_unit.
package regfile_exec_pkg;

  localparam int DW_DEF = 5;
  localparam int AW_DEF = 2;

  typedef enum logic [2:0] {
    OP_LDSEQ = 3'b000,
    OP_LD0   = 3'b001,
    OP_MOV   = 3'b010,
    OP_LDK   = 3'b011,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_AND   = 3'b110,
    OP_XOR   = 3'b111
  } op_t;

  // ALU ops occupy the upper half of the opcode space
  function automatic logic is_alu(input op_t op);
    return op[2];
  endfunction

  function automatic logic is_load(input op_t op);
    return (op == OP_LDSEQ) || (op == OP_LD0) || (op == OP_LDK);
  endfunction

  function automatic logic writes_wa(input op_t op);
    return (op == OP_LDSEQ) || (op == OP_LDK);
  endfunction

endpackage

// File: rtl/regfile_exec_unit_alu.sv
// Combinational execute datapath; REGFILE_EXEC_SAT_EN selects saturating ADD/SUB.
// Non-ALU ops pass operand b through, so loads and moves share the writeback path.
module exec_alu
  import regfile_exec_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  op_t           op_i,
  output logic [DW-1:0] result_o,
  output logic          carry_o
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  // diff[DW] is the borrow: set exactly when a_i < b_i unsigned
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o = b_i;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        carry_o = sum[DW];
`ifdef REGFILE_EXEC_SAT_EN
        result_o = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
`else
        result_o = sum[DW-1:0];
`endif
      end
      OP_SUB: begin
        carry_o = diff[DW];
`ifdef REGFILE_EXEC_SAT_EN
        result_o = diff[DW] ? {DW{1'b0}} : diff[DW-1:0];
`else
        result_o = diff[DW-1:0];
`endif
      end
      OP_AND:  result_o = a_i & b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      default: result_o = b_i;
    endcase
  end

endmodule

// File: rtl/regfile_exec_unit.sv
// Two-stage execute unit: S1 captures the command and forwarded operands, S2 executes and writes back.
// Optional saturating arithmetic is enabled with the REGFILE_EXEC_SAT_EN macro (see exec_alu).
module regfile_exec_unit
  import regfile_exec_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [2:0]    op,
  input  logic [DW-1:0] data_in,
  input  logic [AW-1:0] wa,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic          carry,
  output logic          zero,
  output logic [DW-1:0] rd_data
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] regs_q [NREG];

  logic          s1_valid_q;
  op_t           s1_op_q;
  logic [AW-1:0] s1_dst_q;
  logic [DW-1:0] s1_a_q;
  logic [DW-1:0] s1_b_q;

  logic [DW-1:0] result_q;
  logic          result_valid_q;
  logic          carry_q;
  logic          zero_q;

  op_t           op_in;
  logic [AW-1:0] s1_dst_d;
  logic [DW-1:0] s1_b_d;
  logic [DW-1:0] rd_fwd;
  logic [DW-1:0] r0_fwd;
  logic [DW-1:0] alu_res;
  logic          alu_carry;

  assign op_in = op_t'(op);

  exec_alu #(.DW(DW)) u_alu (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .op_i     (s1_op_q),
    .result_o (alu_res),
    .carry_o  (alu_carry)
  );

  // The S2 writeback lands on the same edge that S1 samples, so bypass it here
  always_comb begin
    rd_fwd = regs_q[ra];
    r0_fwd = regs_q[0];
    if (s1_valid_q && (s1_dst_q == ra)) rd_fwd = alu_res;
    if (s1_valid_q && (s1_dst_q == '0)) r0_fwd = alu_res;
  end

  assign s1_dst_d = writes_wa(op_in) ? wa : '0;
  assign s1_b_d   = is_load(op_in) ? data_in : rd_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_LDSEQ;
      s1_dst_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op_q  <= op_in;
        s1_dst_q <= s1_dst_d;
        s1_a_q   <= r0_fwd;
        s1_b_q   <= s1_b_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (s1_valid_q) begin
      regs_q[s1_dst_q] <= alu_res;
    end
  end

  // Loads and moves leave carry alone; every retired op refreshes zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
      carry_q        <= 1'b0;
      zero_q         <= 1'b0;
    end else begin
      result_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
        if (is_alu(s1_op_q)) carry_q <= alu_carry;
      end
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign carry        = carry_q;
  assign zero         = zero_q;
  assign rd_data      = rd_fwd;

endmodule

// File: doc/regfile_exec_unit.md
Name: regfile_exec_unit

Overview:
- Downstream execute stage of the 5-bit sequencing controller.
- Consumes the controller's per-cycle command: op, write data, write address and read address.
- Holds a 4-entry x 5-bit register file and executes load, move and ALU operations, accumulating into R0.
- Two-stage pipeline (read, execute/writeback) with internal forwarding, carry/zero flags and a result port for the next block.

Parameters:
- DW, 5, data width of registers, data_in and result.
- AW, 2, address width; register count is 2**AW.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command valid this cycle; accepted unconditionally.
- op  input  3  command opcode, encoded in the shared package.
- data_in  input  DW  write data from the controller.
- wa  input  AW  write address.
- ra  input  AW  read address.
- result  output  DW  value written back by the retiring command.
- result_valid  output  1  one-cycle pulse when a command retires.
- carry  output  1  carry/borrow flag from the last ALU op.
- zero  output  1  set when the last retired result == 0.
- rd_data  output  DW  combinational view of R[ra], including forwarding.

Behaviour:
- Reset (async, rst_n low): all registers R0..R3, both pipeline valids, result, result_valid, carry and zero = 0. Takes effect immediately.
- Reset asserted mid-operation discards any in-flight command with no writeback.
- Stage 1 (S1), on an accepted command: capture op, wa and data_in; read operands a = R0 and b = R[ra], both forwarded.
- Stage 2 (S2): compute the result and write it back at the S2 clock edge. result_valid pulses in the cycle after S2, so latency from accept to result_valid is 2 cycles.
- Opcodes:
  - 000 LDSEQ: R[wa] = data_in.
  - 001 LD0: R0 = data_in.
  - 010 MOV: R0 = R[ra].
  - 011 LDK: R[wa] = data_in.
  - 100 ADD: R0 = R0 + R[ra].
  - 101 SUB: R0 = R0 - R[ra].
  - 110 AND: R0 = R0 & R[ra].
  - 111 XOR: R0 = R0 ^ R[ra].
- Arithmetic is DW bits and wraps modulo 2**DW.
- carry:
  - ADD: carry-out of bit DW-1.
  - SUB: borrow, i.e. 1 when R0 < R[ra] unsigned.
  - AND/XOR: cleared.
  - Load and move ops: unchanged.
- zero updates on every retired op.
- Forwarding: when S2 writes register X in the same cycle S1 reads X, S1 uses the S2 result. Back-to-back ADDs therefore accumulate correctly with no bubble.
- Simultaneous write and read of the same address at the register file: write-first.
- in_valid low: a bubble propagates. Registers, flags and result hold; result_valid = 0.
- Address wrap: a 2-bit address covers all 4 entries; there is no invalid address.

Optional Feature:
- Macro: REGFILE_EXEC_SAT_EN.
- Defined: ADD saturates to 2**DW-1 and SUB saturates to 0; carry still reports the raw overflow/borrow.
- Undefined: wrap-around arithmetic only, and no saturation logic is synthesised.

Decomposition:
- Package regfile_exec_pkg holds:
  - op_t enum: OP_LDSEQ, OP_LD0, OP_MOV, OP_LDK, OP_ADD, OP_SUB, OP_AND, OP_XOR.
  - DW/AW defaults.
  - An is_alu(op) function.
- One combinational sub-module, exec_alu: inputs a, b, op; outputs result, carry. Holds the saturation option.
- Register file, pipeline registers and forwarding stay in the top module.

Test Plan:
- Reset: pulse rst_n low mid-stream between clock edges -> all outputs 0 immediately; an in-flight ADD never produces result_valid.
- Load/read: LDK wa=2 data=0x15, then a bubble, then MOV ra=2 -> result=0x15 two cycles after MOV; rd_data(ra=2)=0x15.
- Wrap ADD: R0=0x1F, R1=0x01, ADD ra=1 -> result=0x00, carry=1, zero=1 (REGFILE_EXEC_SAT_EN defined: result=0x1F, carry=1, zero=0).
- Borrow: R0=0x03, R3=0x05, SUB ra=3 -> result=0x1E, carry=1 (SAT defined: 0x00, zero=1).
- Forwarding: LD0 0x02, then ADD ra=0 on the next cycle, then ADD ra=0 on the following cycle -> results 0x02, 0x04, 0x08 on consecutive cycles.
- Bubbles: in_valid low for 3 cycles between commands -> result_valid low during the gap; registers and flags unchanged.
